// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the two-digit BCD down counter.
// Holds the controller state enumeration, the largest legal BCD digit,
// the default prescaler divide ratio and a digit clamp helper.
package bcd_down_counter_pkg;

  // Controller states: waiting, counting autonomously, finished at 00.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX          = 4'd9;
  localparam int         DEFAULT_TICK_DIV = 10;

  // Preset digits above 9 are not BCD; saturate them to 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_down_counter_pair_dec.sv
// bcd_pair_dec: combinational decrement of a two-digit BCD value.
// Ports:
//   tens, ones               - current count digits
//   preset_tens, preset_ones - value reloaded when decrementing from 00
//   dec_en                   - apply one decrement this cycle
//   next_tens, next_ones     - resulting digits (unchanged when dec_en=0)
//   wrap                     - high when the decrement reloaded from 00
module bcd_pair_dec
  import bcd_down_counter_pkg::*;
(
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic       dec_en,
  output logic [3:0] next_tens,
  output logic [3:0] next_ones,
  output logic       wrap
);

  // Borrow from the tens digit when ones is 0; 00 wraps back to the preset.
  always_comb begin
    next_tens = tens;
    next_ones = ones;
    wrap      = 1'b0;
    if (dec_en) begin
      if (ones != 4'd0) begin
        next_ones = ones - 4'd1;
      end else if (tens != 4'd0) begin
        next_ones = BCD_MAX;
        next_tens = tens - 4'd1;
      end else begin
        next_tens = preset_tens;
        next_ones = preset_ones;
        wrap      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: two-digit BCD down counter with preset load,
// edge-triggered manual decrements and a prescaled autonomous countdown.
// Ports:
//   Clk, Reset                  - clock, synchronous active-high reset
//   load, load_tens, load_ones  - capture preset and write it to the count
//   dec_with_underflow          - rising edge decrements, may pulse underflow
//   dec_without_underflow       - rising edge decrements, never pulses underflow
//   run                         - enables the countdown, one step per TICK_DIV cycles
//   count_tens, count_ones      - registered BCD count
//   underflow                   - one-cycle pulse on reload from 00 / final tick
//   zero                        - count is 00
//   done                        - controller is in DONE
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       dec_with_underflow,
  input  logic       dec_without_underflow,
  input  logic       run,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic       underflow,
  output logic       zero,
  output logic       done
);

  localparam logic [15:0] PRESC_TERM = 16'(TICK_DIV - 1);

  state_t      state_q;
  state_t      state_d;
  logic        prev_wu_q;
  logic        prev_wo_q;
  logic [15:0] prescaler_q;
  logic [3:0]  preset_tens_q;
  logic [3:0]  preset_ones_q;

  logic        wu_edge;
  logic        wo_edge;
  logic        tick;
  logic        dec_en;
  logic        count_is_one;
  logic        finish;
  logic [3:0]  dec_tens;
  logic [3:0]  dec_ones;
  logic        wrap;
  logic [3:0]  count_tens_d;
  logic [3:0]  count_ones_d;
  logic        underflow_d;
  logic        done_d;

  assign wu_edge      = dec_with_underflow & ~prev_wu_q;
  assign wo_edge      = dec_without_underflow & ~prev_wo_q;
  assign tick         = (state_q == RUN) && run && (prescaler_q == PRESC_TERM);
  assign dec_en       = ~load & (wu_edge | wo_edge | tick);
  assign count_is_one = (count_tens == 4'd0) && (count_ones == 4'd1);
  // A tick taking 01 down to 00 ends the countdown instead of reloading.
  assign finish       = tick & ~load & count_is_one;

  bcd_pair_dec u_pair_dec (
    .tens        (count_tens),
    .ones        (count_ones),
    .preset_tens (preset_tens_q),
    .preset_ones (preset_ones_q),
    .dec_en      (dec_en),
    .next_tens   (dec_tens),
    .next_ones   (dec_ones),
    .wrap        (wrap)
  );

  // Previous-sample registers for the dec inputs; cleared by reset so a
  // level held through reset release is seen as a fresh edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_wu_q <= 1'b0;
      prev_wo_q <= 1'b0;
    end else begin
      prev_wu_q <= dec_with_underflow;
      prev_wo_q <= dec_without_underflow;
    end
  end

  // Prescaler only advances while running; a load restarts the period.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prescaler_q <= 16'd0;
    end else if (load || (state_q != RUN) || !run) begin
      prescaler_q <= 16'd0;
    end else if (prescaler_q == PRESC_TERM) begin
      prescaler_q <= 16'd0;
    end else begin
      prescaler_q <= prescaler_q + 16'd1;
    end
  end

  // Controller state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (run && !zero) state_d = RUN;
      RUN: begin
        if (!run)        state_d = IDLE;
        else if (finish) state_d = DONE;
      end
      DONE: if (load || !run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    if (load) begin
      count_tens_d = clamp_bcd(load_tens);
      count_ones_d = clamp_bcd(load_ones);
    end else begin
      count_tens_d = dec_tens;
      count_ones_d = dec_ones;
    end
    underflow_d = (wrap & (wu_edge | tick)) | finish;
    done_d      = (state_d == DONE);
  end

  // Count, preset and status output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_tens    <= 4'd0;
      count_ones    <= 4'd0;
      preset_tens_q <= 4'd0;
      preset_ones_q <= 4'd0;
      underflow     <= 1'b0;
      zero          <= 1'b1;
      done          <= 1'b0;
    end else begin
      if (load) begin
        preset_tens_q <= clamp_bcd(load_tens);
        preset_ones_q <= clamp_bcd(load_ones);
      end
      count_tens <= count_tens_d;
      count_ones <= count_ones_d;
      underflow  <= underflow_d;
      zero       <= (count_tens_d == 4'd0) && (count_ones_d == 4'd0);
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: directed scenarios followed by
// random stimulus, all cycles compared against a decimal reference model.
module tb_bcd_down_counter;

  localparam int TB_TICK_DIV = 4;

  logic       Clk;
  logic       Reset;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       dec_with_underflow;
  logic       dec_without_underflow;
  logic       run;
  logic [3:0] count_tens;
  logic [3:0] count_ones;
  logic       underflow;
  logic       zero;
  logic       done;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: count and preset as plain integers 0..99.
  int m_count, m_preset, m_phase, m_mode;
  bit m_prev_wu, m_prev_wo, m_uf;
  localparam int M_IDLE = 0, M_RUNNING = 1, M_FINISHED = 2;

  bcd_down_counter #(.TICK_DIV(TB_TICK_DIV)) dut (
    .Clk                   (Clk),
    .Reset                 (Reset),
    .load                  (load),
    .load_tens             (load_tens),
    .load_ones             (load_ones),
    .dec_with_underflow    (dec_with_underflow),
    .dec_without_underflow (dec_without_underflow),
    .run                   (run),
    .count_tens            (count_tens),
    .count_ones            (count_ones),
    .underflow             (underflow),
    .zero                  (zero),
    .done                  (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int dutCount();
    return int'(count_tens) * 10 + int'(count_ones);
  endfunction

  // One clock of the behavioural model, using the inputs about to be sampled.
  function automatic void modelStep(input bit r, input bit l, input int lt, input int lo,
                                    input bit wu, input bit wo, input bit rn);
    bit wuE, woE, tk;
    int oldCount;
    if (r) begin
      m_count = 0; m_preset = 0; m_phase = 0; m_mode = M_IDLE;
      m_prev_wu = 0; m_prev_wo = 0; m_uf = 0;
      return;
    end
    wuE = wu && !m_prev_wu;
    woE = wo && !m_prev_wo;
    m_prev_wu = wu;
    m_prev_wo = wo;
    tk = (m_mode == M_RUNNING) && rn && (m_phase == TB_TICK_DIV - 1);
    oldCount = m_count;
    m_uf = 0;
    if (l) begin
      m_preset = ((lt > 9) ? 9 : lt) * 10 + ((lo > 9) ? 9 : lo);
      m_count = m_preset;
    end else if (wuE || woE || tk) begin
      if (m_count == 0) begin
        m_count = m_preset;
        m_uf = wuE || tk;
      end else begin
        if (tk && m_count == 1) m_uf = 1;
        m_count = m_count - 1;
      end
    end
    if (l || m_mode != M_RUNNING || !rn) m_phase = 0;
    else m_phase = (m_phase + 1) % TB_TICK_DIV;
    case (m_mode)
      M_IDLE:    if (rn && oldCount != 0) m_mode = M_RUNNING;
      M_RUNNING: if (!rn) m_mode = M_IDLE;
                 else if (tk && !l && oldCount == 1) m_mode = M_FINISHED;
      default:   if (l || !rn) m_mode = M_IDLE;
    endcase
  endfunction

  // Drive one cycle of inputs, advance model and DUT, compare all outputs.
  task automatic applyStimulus(input bit r, input bit l, input logic [3:0] lt,
                               input logic [3:0] lo, input bit wu, input bit wo,
                               input bit rn);
    Reset = r; load = l; load_tens = lt; load_ones = lo;
    dec_with_underflow = wu; dec_without_underflow = wo; run = rn;
    modelStep(r, l, int'(lt), int'(lo), wu, wo, rn);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("count", dutCount(), m_count);
    checkOutput("underflow", int'(underflow), int'(m_uf));
    checkOutput("zero", int'(zero), int'(m_count == 0));
    checkOutput("done", int'(done), int'(m_mode == M_FINISHED));
  endtask

  initial begin
    int exp36 [4] = '{22, 21, 20, 19};
    int guard;
    Reset = 1'b1; load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
    dec_with_underflow = 1'b0; dec_without_underflow = 1'b0; run = 1'b0;
    @(negedge Clk);

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 4'd5, 4'd5, 1, 1, 1);
    checkOutput("rst_count", dutCount(), 0);
    checkOutput("rst_zero", int'(zero), 1);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_uf", int'(underflow), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Preset 23, four edges without underflow
    applyStimulus(0, 1, 4'd2, 4'd3, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("dec_wo_count", dutCount(), exp36[i]);
      checkOutput("dec_wo_uf", int'(underflow), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end

    // Preset 01, two edges with underflow
    applyStimulus(0, 1, 4'd0, 4'd1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("uf_first_count", dutCount(), 0);
    checkOutput("uf_first_zero", int'(zero), 1);
    checkOutput("uf_first_uf", int'(underflow), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("uf_reload_count", dutCount(), 1);
    checkOutput("uf_reload_uf", int'(underflow), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("uf_pulse_end", int'(underflow), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Preset 05, count to 00, then both edges together
    applyStimulus(0, 1, 4'd0, 4'd5, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("both_pre_count", dutCount(), 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("both_count", dutCount(), 5);
    checkOutput("both_uf", int'(underflow), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Load with clamping beats a simultaneous dec edge
    applyStimulus(0, 1, 4'd12, 4'd3, 1, 0, 0);
    checkOutput("load_prio_count", dutCount(), 93);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Autonomous countdown from 02 with TICK_DIV=4
    applyStimulus(0, 1, 4'd0, 4'd2, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      if (i == 5) checkOutput("run_first_tick", dutCount(), 1);
    end
    checkOutput("run_end_count", dutCount(), 0);
    checkOutput("run_end_uf", int'(underflow), 1);
    checkOutput("run_end_done", int'(done), 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("run_hold_count", dutCount(), 0);
    checkOutput("run_hold_done", int'(done), 1);

    // Reset in the middle of a countdown with dec_with_underflow held
    applyStimulus(0, 1, 4'd0, 4'd9, 0, 0, 1);
    guard = 0;
    while (dutCount() != 7 && guard < 100) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      guard++;
    end
    checkOutput("rst_run_reach07", dutCount(), 7);
    applyStimulus(1, 0, 0, 0, 1, 0, 1);
    checkOutput("rst_run_count", dutCount(), 0);
    checkOutput("rst_run_uf", int'(underflow), 0);
    checkOutput("rst_run_done", int'(done), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("rel_count", dutCount(), 0);
    checkOutput("rel_uf", int'(underflow), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("rel_single", int'(underflow), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 19) == 0,
                    4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10, giving the number of Clk cycles per run-mode tick (legal range 2..65535).
REQ-002 SHALL have port Clk, input, 1, the single clock; all state SHALL update on the rising edge only.
REQ-003 SHALL have port Reset, input, 1, with synchronous, active-high reset.
REQ-004 SHALL have port load, input, 1: level-sampled preset load strobe.
REQ-005 SHALL have ports load_tens and load_ones, input, 4 each: BCD preset digits.
REQ-006 SHALL have port dec_with_underflow, input, 1: decrement request that may raise underflow; acts on its rising edge.
REQ-007 SHALL have port dec_without_underflow, input, 1: decrement request that never raises underflow; acts on its rising edge.
REQ-008 SHALL have port run, input, 1: level enable for the autonomous prescaled countdown.
REQ-009 SHALL have ports count_tens and count_ones, output, 4 each, registered: current BCD value.
REQ-010 SHALL have port underflow, output, 1, registered: one-cycle pulse.
REQ-011 SHALL have port zero, output, 1, registered: high whenever the count is 00.
REQ-012 SHALL have port done, output, 1, registered: high while the FSM is in DONE.

Function
REQ-013 SHALL detect a rising edge on each dec input as input==1 while its previous-sample register==0; the previous-sample registers SHALL update every non-reset cycle.
REQ-014 SHALL apply at most one decrement per cycle; rising edges on both dec inputs in one cycle produce one decrement, and the with-underflow edge governs the underflow response.
REQ-015 Decrement rules: ones>0 -> ones-1; ones==0 and tens>0 -> ones=9, tens-1; count 00 -> reload the stored preset.
REQ-016 On a 00 reload caused by dec_with_underflow or a run tick, underflow SHALL be 1 for exactly that cycle; otherwise underflow SHALL be 0.
REQ-017 When load==1, the block SHALL capture the preset (each digit >9 clamped to 9), write it to the count, and clear the prescaler; load SHALL take priority over any decrement in the same cycle.
REQ-018 Outputs SHALL reflect a decrement on the same Clk edge at which the triggering edge is sampled, giving one-cycle latency from input to output.
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 FSM transition IDLE -> RUN when run==1 and the count is not 00.
REQ-021 FSM transition RUN -> IDLE when run==0.
REQ-022 FSM transition RUN -> DONE when a run tick decrements 01 to 00 (00 is held with no reload, and underflow is pulsed).
REQ-023 FSM transitions DONE -> IDLE on load==1 or run==0.
REQ-024 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and issue a tick at terminal count, then wrap to 0.
REQ-025 In IDLE and DONE, the prescaler SHALL be held at 0.
REQ-026 A tick coinciding with a dec edge SHALL be merged into a single decrement.
REQ-027 Dec edges SHALL be honoured in every state; in DONE, a decrement from 00 reloads the preset and the FSM stays in DONE.
REQ-028 zero SHALL equal (count_tens==0 && count_ones==0) on the registered value.

Reset
REQ-029 When Reset==1, the block SHALL set count 00, preset 00, underflow 0, zero 1, done 0, prescaler 0, FSM IDLE, and both previous-sample registers 0.
REQ-030 Reset SHALL override load, dec and run inputs.
REQ-031 A dec input held high through reset release SHALL yield exactly one decrement in the first non-reset cycle.
REQ-032 Reset asserted mid-RUN SHALL abort the countdown on the same edge, with no underflow pulse.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration (2-bit), the BCD_MAX=9 constant and the default TICK_DIV.
REQ-034 The BCD digit-pair decrement/reload logic SHALL be a single sub-module, bcd_pair_dec, which is combinational: inputs current digits, preset and the decrement enable; outputs next digits and a wrap flag.
REQ-035 Edge detection, the prescaler and the FSM SHALL remain in the top level.

Verification
REQ-036 Preset 23, then 4 rising edges on dec_without_underflow -> count 22, 21, 20, 19; underflow 0 throughout.
REQ-037 Preset 01, then 2 rising edges on dec_with_underflow -> 00 (zero=1), then reload 01 with a 1-cycle underflow pulse.
REQ-038 Rising edges on both dec inputs in the same cycle from count 00 with preset 05 -> single reload to 05, underflow=1.
REQ-039 Load preset tens=12, ones=3 together with a dec edge in the same cycle -> count 93, no decrement applied.
REQ-040 TICK_DIV=4, preset 02, run=1 -> count 01 after 4 cycles, then 00 after 8 cycles with an underflow pulse, done=1, and the count held at 00.
REQ-041 Reset asserted during RUN at count 07, with dec_with_underflow held high -> count 00, IDLE; after release, a single decrement from 00 reloads preset 00 with an underflow pulse.
